// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer. It borrows the shared ALU for
// one ADD (shift-add multiply) or SUB (restoring divide) per cycle, XLEN cycles per op.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            sel_hi;

    // acc holds hi (multiply) or rem (divide); q holds lo or quo; d holds mcand or dvs.
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] d;

    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] q_nx;
    logic [XLEN-1:0] sh_lo;
    logic            sh_top;
    logic            take;
    logic            carry;

    // Divide view: sh = {rem, quo[MSB]} is XLEN+1 bits; sh_top set means sh > any divisor.
    always_comb begin
        sh_lo  = {acc[XLEN-2:0], q[XLEN-1]};
        sh_top = acc[XLEN-1];
        take   = sh_top | (sh_lo >= d);
        carry  = (alu_result < acc);
    end

    always_comb begin
        alu_req  = (state == RUN);
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        if (state == RUN) begin
            if (is_div) begin
                alu_a    = sh_lo;
                alu_b    = d;
                alu_ctrl = ALU_SUB;
            end else begin
                alu_a    = acc;
                alu_b    = q[0] ? d : '0;
                alu_ctrl = ALU_ADD;
            end
        end
    end

    always_comb begin
        if (is_div) begin
            if (take) begin
                acc_nx = alu_result;
                q_nx   = {q[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = sh_lo;
                q_nx   = {q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = {carry, alu_result[XLEN-1:1]};
            q_nx   = {alu_result[0], q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sel_hi <= 1'b0;
            acc    <= '0;
            q      <= '0;
            d      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div <= op[1];
                        sel_hi <= op[0];
                        cnt    <= '0;
                        acc    <= '0;
                        q      <= rs1;
                        d      <= rs2;
                        busy   <= 1'b1;
                        if (op[1] && (rs2 == '0)) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= op[0] ? rs1 : '1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        // hi/rem live in acc, lo/quo in q, so op[0] picks the same way for both
                        result <= sel_hi ? acc_nx : q_nx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized bench for alu_muldiv_seq against a cycle-level behavioural model that
// derives results with plain 64-bit arithmetic and an abstract op timeline.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .result(result), .alu_req(alu_req),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign alu_result = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    longint      cyc = 0;

    int          m_phase = P_IDLE;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_b = '0;
    bit          m_div = 1'b0;
    longint      acc_cyc = 0;
    longint      prev_acc_cyc = 0;

    function automatic logic [31:0] ref_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Abstract timeline: accepted op spends 32 cycles owning the ALU then one done cycle;
    // a zero divisor skips straight to the done cycle.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_phase = P_IDLE;
            m_res   = '0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    prev_acc_cyc = acc_cyc;
                    acc_cyc      = cyc;
                    m_pend       = ref_fn(op, rs1, rs2);
                    m_div        = op[1];
                    m_b          = rs2;
                    if (op[1] && rs2 == 0) begin
                        m_phase = P_DONE;
                        m_res   = m_pend;
                    end else begin
                        m_phase = P_RUN;
                        m_left  = 32;
                    end
                end
                P_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_DONE;
                        m_res   = m_pend;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle_checks();
        check("busy", {31'd0, busy}, {31'd0, m_phase != P_IDLE});
        check("done", {31'd0, done}, {31'd0, m_phase == P_DONE});
        check("alu_req", {31'd0, alu_req}, {31'd0, m_phase == P_RUN});
        check("result", result, m_res);
        if (m_phase != P_RUN) begin
            check("idle alu_a", alu_a, 32'd0);
            check("idle alu_b", alu_b, 32'd0);
            check("idle alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        end else begin
            check("run alu_ctrl", {28'd0, alu_ctrl}, m_div ? 32'd1 : 32'd0);
            if (m_div) check("div alu_b", alu_b, m_b);
            else       check("mul alu_b", alu_b, (alu_b == 0) ? 32'd0 : m_b);
        end
    endtask

    // mode 0: quiet inputs, 1: scramble inputs and stray starts while busy,
    // 2: one stray DIVU 9/3 start after 10 RUN edges
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int exp_req,
                         input int mode, input string name);
        int lat;
        int nreq;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat  = 1;
        nreq = int'(alu_req);
        while (!done && lat < 100) begin
            start = 1'b0;
            if (mode == 1) begin
                op    = 2'($urandom);
                rs1   = $urandom;
                rs2   = $urandom;
                start = ($urandom_range(0, 5) == 0);
            end else if (mode == 2 && lat == 11) begin
                start = 1'b1; op = 2'd2; rs1 = 32'd9; rs2 = 32'd3;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
            nreq += int'(alu_req);
        end
        start = 1'b0;
        check({name, " result"}, result, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " alu_req cycles"}, nreq, exp_req);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        bit          dz;

        reset = 1'b1; start = 1'b0; op = 2'd0; rs1 = '0; rs2 = '0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) cycle_checks();
            end
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        do_op(2'd0, 32'd7, 32'd6, 32'h0000_002A, 33, 32, 0, "MUL 7x6");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, 1, "MULHU max");
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32, 0, "MUL max");
        do_op(2'd2, 32'd100, 32'd7, 32'h0000_000E, 33, 32, 0, "DIVU 100/7");
        do_op(2'd3, 32'd100, 32'd7, 32'h0000_0002, 33, 32, 1, "REMU 100/7");
        do_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 33, 32, 0, "DIVU wide");
        do_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 32, 0, "REMU wide");
        do_op(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, "DIVU by 0");
        do_op(2'd3, 32'd5, 32'd0, 32'h0000_0005, 1, 0, 0, "REMU by 0");

        // Stray start mid-run is dropped; the real follow-up starts in the IDLE cycle after done
        do_op(2'd0, 32'd3, 32'd5, 32'd15, 33, 32, 2, "MUL 3x5 stray start");
        do_op(2'd2, 32'd9, 32'd3, 32'd3, 33, 32, 0, "DIVU 9/3");
        // 34 edges between accepting edges: a 35-cycle window counting both start cycles
        check("start-to-start edges", 32'(acc_cyc - prev_acc_cyc), 32'd34);

        // Reset after 10 RUN edges of a MULHU
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid-op reset busy", {31'd0, busy}, 32'd0);
        check("mid-op reset done", {31'd0, done}, 32'd0);
        check("mid-op reset result", result, 32'd0);
        check("mid-op reset alu_req", {31'd0, alu_req}, 32'd0);
        reset = 1'b0;
        do_op(2'd0, 32'd2, 32'd2, 32'd4, 33, 32, 0, "MUL 2x2 after reset");

        // Reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'd0; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        check("reset+start busy", {31'd0, busy}, 32'd0);
        reset = 1'b0; start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 255);
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            dz = o[1] && (b == 0);
            do_op(o, a, b, ref_fn(o, a, b), dz ? 1 : 33, dz ? 0 : 32, 1, "random op");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
